// File: rtl/ws2812_rx_pkg.sv
// Shared WS2812 definitions for the receiver (the transmitter uses the same timing set).
// Holds line timing constants, pixel geometry, decoder state encodings and a saturating helper.
// No ports; import with ws2812_rx_pkg::*.
package ws2812_rx_pkg;

    // Transmitter line timing in core clocks at 16 MHz.
    localparam int T_ON    = 13;    // high time of a '1' (low time of a '0')
    localparam int T_OFF   = 7;     // high time of a '0' (low time of a '1')
    localparam int T_RESET = 1020;  // low gap the transmitter emits between frames

    // Receiver defaults. The bit threshold sits midway between the two legal high widths.
    localparam int T_BIT_THRESH_DEF = (T_ON + T_OFF) / 2;  // 10
    localparam int T_GLITCH_DEF     = 2;
    localparam int T_HIGH_MAX_DEF   = 40;
    localparam int T_RESET_MIN_DEF  = 800;

    localparam int BITS_PER_LED = 24;
    localparam int RUN_W        = 10;  // run-length counter width
    localparam int BIT_CNT_W    = 5;   // counts 0..23

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,  // waiting for a long low run before trusting the line
        ST_LOW  = 2'd1,  // line low, between bits
        ST_HIGH = 2'd2   // measuring a high pulse
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Brings the asynchronous WS2812 line into clk: 2-flop synchronizer plus a registered edge detector.
// Ports: clk, reset (async active-low), din (raw pin) -> line_o (synchronized level), rise_o, fall_o.
// Latency: line_o follows din by 2 clk; rise_o/fall_o are high in the first cycle line_o shows the new level.
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic line_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            line_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            line_q <= meta_q;
            prev_q <= line_q;
        end
    end

    // Both operands are flops, so the edge pulses are clean single-cycle strobes.
    assign line_o = line_q;
    assign rise_o = line_q & ~prev_q;
    assign fall_o = ~line_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high pulse widths as bits, assembles 24-bit pixels MSB first,
// reports each with a 1-cycle valid, and flags the end-of-frame low gap and line errors.
// Ports: clk, reset (async active-low), din -> rgb_data, led_num, valid, frame_done, frame_leds, err
// (+ dout when WS2812_RX_PASSTHRU_EN is defined: only pixel 0 is decoded, the rest is forwarded on dout).
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int T_BIT_THRESH = T_BIT_THRESH_DEF,
    parameter int T_GLITCH     = T_GLITCH_DEF,
    parameter int T_HIGH_MAX   = T_HIGH_MAX_DEF,
    parameter int T_RESET_MIN  = T_RESET_MIN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
`ifdef WS2812_RX_PASSTHRU_EN
    output logic        dout,
`endif
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic [7:0]  frame_leds,
    output logic        err
);

    logic line;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .line_o (line),
        .rise_o (rise),
        .fall_o (fall)
    );

    rx_state_e            state_q;
    logic [RUN_W-1:0]     run_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [22:0]          shift_q;     // the 24th bit goes straight into rgb_q
    logic [7:0]           pix_cnt_q;
    logic                 bits_seen_q; // any bit counted since the last gap
    logic [23:0]          rgb_q;
    logic [7:0]           led_num_q;
    logic                 valid_q;
    logic                 frame_done_q;
    logic [7:0]           frame_leds_q;
    logic                 err_q;

    // Run-length counter. It restarts at 1 on an edge so that at a falling edge it holds exactly
    // the number of cycles the line was high. It stops at T_RESET_MIN so a long idle line does
    // not wrap and fake a second gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else if (rise || fall) begin
            run_q <= RUN_W'(1);
        end else if (run_q != RUN_W'(T_RESET_MIN)) begin
            run_q <= run_q + RUN_W'(1);
        end
    end

    logic run_gap;   // this cycle completes a low run of T_RESET_MIN; fires once per run
    logic bit_val;
    logic glitch;
    logic too_long;  // still high after T_HIGH_MAX cycles, so the width exceeds the limit
    logic last_bit;
    logic decode_en;

    assign run_gap  = ~line & ~rise & ~fall & (run_q == RUN_W'(T_RESET_MIN - 1));
    assign bit_val  = (run_q >= RUN_W'(T_BIT_THRESH));
    assign glitch   = (run_q < RUN_W'(T_GLITCH));
    assign too_long = (run_q >= RUN_W'(T_HIGH_MAX));
    assign last_bit = (bit_cnt_q == BIT_CNT_W'(BITS_PER_LED - 1));

`ifdef WS2812_RX_PASSTHRU_EN
    logic fwd_q;
    logic fwd_start;

    // Chip-like: once pixel 0 is captured the rest of the frame belongs downstream.
    assign decode_en = (pix_cnt_q == 8'd0);
    // Forwarding opens on a rising edge seen from LOW, so it never begins part-way through a pulse.
    assign fwd_start = (state_q == ST_LOW) && rise && !decode_en;
    // Combinational so the opening rise is not clipped; dout is the synchronized line, 2 clk behind din.
    assign dout      = line & (fwd_q | fwd_start);
`else
    assign decode_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pix_cnt_q    <= '0;
            bits_seen_q  <= 1'b0;
            rgb_q        <= '0;
            led_num_q    <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_leds_q <= '0;
            err_q        <= 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
            fwd_q        <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    if (run_gap) begin
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_q <= ST_HIGH;
`ifdef WS2812_RX_PASSTHRU_EN
                        if (fwd_start) begin
                            fwd_q <= 1'b1;
                        end
`endif
                    end else if (run_gap) begin
                        // End of frame: a leftover bit count means the last pixel was cut short.
                        if (bit_cnt_q != '0) begin
                            err_q <= 1'b1;
                        end
                        if (bits_seen_q) begin
                            frame_done_q <= 1'b1;
                            frame_leds_q <= pix_cnt_q;
                        end
                        bit_cnt_q   <= '0;
                        pix_cnt_q   <= '0;
                        bits_seen_q <= 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
                        fwd_q       <= 1'b0;
`endif
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_q <= ST_LOW;
                        if (!glitch && decode_en) begin
                            bits_seen_q <= 1'b1;
                            if (last_bit) begin
                                rgb_q     <= {shift_q, bit_val};
                                led_num_q <= pix_cnt_q;
                                valid_q   <= 1'b1;
                                pix_cnt_q <= sat_inc8(pix_cnt_q);
                                bit_cnt_q <= '0;
                            end else begin
                                shift_q   <= {shift_q[21:0], bit_val};
                                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            end
                        end
                    end else if (too_long) begin
                        // Line is stuck high: drop the frame and re-qualify the line from scratch.
                        err_q       <= 1'b1;
                        state_q     <= ST_SYNC;
                        bit_cnt_q   <= '0;
                        pix_cnt_q   <= '0;
                        bits_seen_q <= 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
                        fwd_q       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign rgb_data   = rgb_q;
    assign led_num    = led_num_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign frame_leds = frame_leds_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Testbench for ws2812_rx: drives WS2812 waveforms on din and scoreboards decoded pixels and frame events.
// Latency: n/a (bench).
// Backpressure: none; the receiver has no flow control.
module tb_ws2812_rx;
    import ws2812_rx_pkg::*;

    logic        clk;
    logic        reset;
    logic        din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid;
    logic        frame_done;
    logic [7:0]  frame_leds;
    logic        err;
`ifdef WS2812_RX_PASSTHRU_EN
    logic        dout;
`endif

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
`ifdef WS2812_RX_PASSTHRU_EN
        .dout       (dout),
`endif
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .frame_leds (frame_leds),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  led;
    } pix_t;

    typedef struct {
        logic [23:0] rgb;   // pixel sent
        logic [7:0]  led;   // expected led_num
        bit          last;  // frame gap follows this pixel
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fall_cyc = 0;
    int   last_valid_cyc = 0;
    int   err_seen = 0;
    int   exp_err  = 0;
    pix_t exp_pix_q[$];
    logic [7:0] exp_fd_q[$];
    pix_t mon_p;
    logic [7:0] mon_f;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every output event is matched against what the stimulus queued.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            last_valid_cyc = cyc;
            if (exp_pix_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL valid_unexpected: got rgb_data %06h led_num %0d, want no valid", rgb_data, led_num);
            end else begin
                mon_p = exp_pix_q.pop_front();
                check("rgb_data", {8'h0, rgb_data}, {8'h0, mon_p.rgb});
                check("led_num", {24'h0, led_num}, {24'h0, mon_p.led});
            end
        end
        if (frame_done === 1'b1) begin
            if (exp_fd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_done_unexpected: got frame_leds %0d, want no frame_done", frame_leds);
            end else begin
                mon_f = exp_fd_q.pop_front();
                check("frame_leds", {24'h0, frame_leds}, {24'h0, mon_f});
            end
        end
        if (err === 1'b1) err_seen++;
    end

`ifdef WS2812_RX_PASSTHRU_EN
    bit   pt_fwd = 1'b0;   // 1 while dout should mirror din, else dout must be 0
    logic d0 = 1'b0;
    logic d1 = 1'b0;
    always @(negedge clk) begin
        check("dout", {31'h0, dout}, {31'h0, pt_fwd ? d1 : 1'b0});
        d1 = d0;
        d0 = din;
    end
`endif

    // Hold din at v for n clock cycles.
    task automatic drive(input logic v, input int n);
        @(posedge clk);
        #1;
        if (din === 1'b1 && v == 1'b0) fall_cyc = cyc;
        din = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_width(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_width(T_ON, T_OFF);
        else   send_width(T_OFF, T_ON);
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gap(input logic [7:0] leds);
        exp_fd_q.push_back(leds);
        drive(1'b0, T_RESET);
    endtask

    task automatic expect_pix(input logic [23:0] rgb, input logic [7:0] led);
        pix_t p;
        p.rgb = rgb;
        p.led = led;
        exp_pix_q.push_back(p);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_pix_pending"}, exp_pix_q.size(), 0);
        check({tag, "_fd_pending"}, exp_fd_q.size(), 0);
        check({tag, "_err_count"}, err_seen, exp_err);
    endtask

    task automatic check_reset_outputs();
        check("rst_rgb_data", {8'h0, rgb_data}, 32'h0);
        check("rst_led_num", {24'h0, led_num}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_frame_leds", {24'h0, frame_leds}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{rgb: 24'h123456, led: 8'd0, last: 1'b0};
        vecs[1] = '{rgb: 24'hABCDEF, led: 8'd1, last: 1'b0};
        vecs[2] = '{rgb: 24'h000001, led: 8'd2, last: 1'b1};
        vecs[3] = '{rgb: 24'h800000, led: 8'd0, last: 1'b0};
        vecs[4] = '{rgb: 24'h000000, led: 8'd1, last: 1'b1};
        vecs[5] = '{rgb: 24'hFFFFFF, led: 8'd0, last: 1'b1};

        reset = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;

        // Single pixel after the line qualifies; also measures pin-to-valid latency.
        drive(1'b0, T_RESET_MIN_DEF + 10);
        expect_pix(24'hFF0000, 8'd0);
        send_bits(24'hFF0000, 24);
        drive(1'b0, 20);
        check("valid_latency", last_valid_cyc - fall_cyc, 3);
        gap(8'd1);
        checkpoint("t1");

`ifdef WS2812_RX_PASSTHRU_EN
        // Only pixel 0 is decoded; pixel 1 must appear on dout 2 clk behind din.
        expect_pix(24'h111111, 8'd0);
        send_bits(24'h111111, 24);
        pt_fwd = 1'b1;
        send_bits(24'h222222, 24);
        gap(8'd1);
        pt_fwd = 1'b0;
        checkpoint("t7");
`else
        // Table of frames: led_num counts within a frame and restarts after each gap.
        for (int i = 0; i < 6; i++) begin
            expect_pix(vecs[i].rgb, vecs[i].led);
            send_bits(vecs[i].rgb, 24);
            if (vecs[i].last) gap(vecs[i].led + 8'd1);
        end
        checkpoint("t2");

        // Partial pixel at frame end: err and frame_done together, no complete pixels.
        send_bits(24'h0002AB, 10);
        exp_err++;
        gap(8'd0);
        checkpoint("t3");

        // 1-clk glitch between bits is ignored; then width boundaries 10/9/2/40.
        expect_pix(24'hA5A5A5, 8'd0);
        for (int i = 23; i >= 0; i--) begin
            logic [23:0] a5;
            a5 = 24'hA5A5A5;
            send_bit(a5[i]);
            if (i == 12) begin
                drive(1'b1, 1);
                drive(1'b0, 8);
            end
        end
        expect_pix(24'h93C0F3, 8'd1);
        send_width(10, 10);
        send_width(9, 11);
        send_width(2, 18);
        send_width(40, 10);
        send_bits(24'h03C0F3, 20);
        gap(8'd2);
        checkpoint("t4");

        // Over-long high mid-pixel: err, resync; bits before the 800-clk low are ignored.
        send_bits(24'h0000C3, 8);
        drive(1'b1, 41);
        exp_err++;
        drive(1'b0, 10);
        send_bits(24'h00001F, 5);
        drive(1'b0, T_RESET_MIN_DEF);
        expect_pix(24'h00FF00, 8'd0);
        send_bits(24'h00FF00, 24);
        gap(8'd1);
        checkpoint("t5");

        // Reset mid-pixel clears outputs; a pixel without the low preamble is ignored.
        send_bits(24'h000ABC, 12);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        drive(1'b0, 20);
        send_bits(24'h0F0F0F, 24);
        drive(1'b0, T_RESET_MIN_DEF);
        expect_pix(24'h3C3C3C, 8'd0);
        send_bits(24'h3C3C3C, 24);
        gap(8'd1);
        checkpoint("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
